// File: rtl/bt_cmd_scheduler_if.sv
// Bluetooth command scheduler bus: receiver/timer inputs and game-core outputs.
// Master drives the received bytes and step pulses; slave is the scheduler.
interface bt_cmd_scheduler_if #(
    parameter int QW = 3
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          step;
    logic [1:0]    dir;
    logic          dir_changed;
    logic          paused;
    logic          restart;
    logic          overflow;
    logic [QW-1:0] queue_level;
    logic          link_lost;

    modport master (
        output rx_data, rx_valid, step,
        input  dir, dir_changed, paused, restart, overflow, queue_level, link_lost
    );

    modport slave (
        input  rx_data, rx_valid, step,
        output dir, dir_changed, paused, restart, overflow, queue_level, link_lost
    );
endinterface

// File: rtl/bt_cmd_scheduler.sv
// Decodes Bluetooth ASCII commands, queues direction requests and applies one per
// game step with reversal blocking; also runs a link-loss watchdog.
module bt_cmd_scheduler #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 500000000,
    parameter logic [1:0] INIT_DIR   = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    bt_cmd_scheduler_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    dir_q, dir_d;
    logic          dir_changed_q, dir_changed_d;
    logic          paused_q, paused_d;
    logic          restart_q, restart_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic          is_dir, is_pause, is_restart;
    logic [1:0]    dec_dir, ref_dir, pop_entry;
    logic          fifo_empty, fifo_full, pop_en, push_want, push_en;

    always_comb begin
        is_dir     = 1'b0;
        is_pause   = 1'b0;
        is_restart = 1'b0;
        dec_dir    = 2'b00;
        if (bus.rx_valid) begin
            case (bus.rx_data)
                8'h77, 8'h57: begin is_dir = 1'b1; dec_dir = 2'b00; end
                8'h64, 8'h44: begin is_dir = 1'b1; dec_dir = 2'b01; end
                8'h73, 8'h53: begin is_dir = 1'b1; dec_dir = 2'b10; end
                8'h61, 8'h41: begin is_dir = 1'b1; dec_dir = 2'b11; end
                8'h70, 8'h50: is_pause   = 1'b1;
                8'h72, 8'h52: is_restart = 1'b1;
                default: ;
            endcase
        end
    end

    // Duplicate check compares against the newest queued entry, not the live direction.
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign ref_dir    = fifo_empty ? dir_q : mem_q[wr_ptr_q - PW'(1)];
    assign pop_entry  = mem_q[rd_ptr_q];
    assign pop_en     = bus.step && !paused_q && !fifo_empty && !is_restart;
    assign push_want  = is_dir && (dec_dir != ref_dir);
    assign push_en    = push_want && (!fifo_full || pop_en);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        paused_d      = paused_q;
        restart_d     = 1'b0;
        overflow_d    = 1'b0;
        wd_cnt_d      = wd_cnt_q;

        if (bus.rx_valid)
            wd_cnt_d = '0;
        else if (wd_cnt_q != CW'(TIMEOUT))
            wd_cnt_d = wd_cnt_q + CW'(1);

        if (is_restart) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            dir_d     = INIT_DIR;
            paused_d  = 1'b0;
            restart_d = 1'b1;
        end else begin
            if (push_en)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (pop_entry != (dir_q ^ 2'b10)) begin
                    dir_d         = pop_entry;
                    dir_changed_d = 1'b1;
                end
            end
            if (push_en && !pop_en)
                level_d = level_q + LW'(1);
            else if (pop_en && !push_en)
                level_d = level_q - LW'(1);
            overflow_d = push_want && !push_en;
            if (is_pause)
                paused_d = !paused_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            dir_q         <= INIT_DIR;
            dir_changed_q <= 1'b0;
            paused_q      <= 1'b0;
            restart_q     <= 1'b0;
            overflow_q    <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            paused_q      <= paused_d;
            restart_q     <= restart_d;
            overflow_q    <= overflow_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (!rst && push_en)
            mem_q[wr_ptr_q] <= dec_dir;
    end

    assign bus.dir         = dir_q;
    assign bus.dir_changed = dir_changed_q;
    assign bus.paused      = paused_q;
    assign bus.restart     = restart_q;
    assign bus.overflow    = overflow_q;
    assign bus.queue_level = level_q;
    assign bus.link_lost   = (wd_cnt_q == CW'(TIMEOUT));
endmodule

// File: tb/tb_bt_cmd_scheduler.sv
// Bench for bt_cmd_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal pins, then randomized command traffic.
module tb_bt_cmd_scheduler;
    localparam int         DEPTH = 4;
    localparam int         TMO   = 100;
    localparam logic [1:0] INIT  = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bt_cmd_scheduler_if #(.QW($clog2(DEPTH) + 1)) bus ();

    bt_cmd_scheduler #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO),
        .INIT_DIR  (INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] m_dir = INIT;
    bit         m_paused = 0;
    bit         m_dc = 0, m_ovf = 0, m_rs = 0;
    int         m_wd = 0;
    logic [1:0] q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 ignored, 1 direction, 2 pause, 3 restart
    task automatic decode(input logic [7:0] b, output int kind, output logic [1:0] d);
        kind = 0;
        d    = 2'b00;
        if (b == "w" || b == "W") begin kind = 1; d = 2'b00; end
        else if (b == "d" || b == "D") begin kind = 1; d = 2'b01; end
        else if (b == "s" || b == "S") begin kind = 1; d = 2'b10; end
        else if (b == "a" || b == "A") begin kind = 1; d = 2'b11; end
        else if (b == "p" || b == "P") kind = 2;
        else if (b == "r" || b == "R") kind = 3;
    endtask

    task automatic model(input bit r, input bit v, input logic [7:0] b, input bit s);
        int         kind;
        logic [1:0] d, refd, e;
        bit         pop, dopush;
        m_dc = 0; m_ovf = 0; m_rs = 0;
        if (r) begin
            q.delete(); m_dir = INIT; m_paused = 0; m_wd = 0;
            return;
        end
        if (v) m_wd = 0;
        else if (m_wd < TMO) m_wd++;
        kind = 0; d = 2'b00;
        if (v) decode(b, kind, d);
        if (kind == 3) begin
            q.delete(); m_dir = INIT; m_paused = 0; m_rs = 1;
            return;
        end
        pop    = s && !m_paused && (q.size() > 0);
        dopush = 0;
        if (kind == 1) begin
            refd = (q.size() > 0) ? q[$] : m_dir;
            if (d != refd) begin
                if (q.size() < DEPTH || pop) dopush = 1;
                else m_ovf = 1;
            end
        end
        if (pop) begin
            e = q.pop_front();
            if (e != (m_dir ^ 2'b10)) begin
                m_dir = e;
                m_dc  = 1;
            end
        end
        if (dopush) q.push_back(d);
        if (kind == 2) m_paused = !m_paused;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] b, input bit s);
        @(negedge clk);
        rst          = r;
        bus.rx_valid = v;
        bus.rx_data  = b;
        bus.step     = s;
        model(r, v, b, s);
        @(posedge clk);
        #1;
        chk("dir",         int'(bus.dir),         int'(m_dir));
        chk("dir_changed", int'(bus.dir_changed), int'(m_dc));
        chk("paused",      int'(bus.paused),      int'(m_paused));
        chk("restart",     int'(bus.restart),     int'(m_rs));
        chk("overflow",    int'(bus.overflow),    int'(m_ovf));
        chk("queue_level", int'(bus.queue_level), q.size());
        chk("link_lost",   int'(bus.link_lost),   int'(m_wd == TMO));
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.step     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(0, 1, b, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
    endtask

    task automatic stp();
        cyc(0, 0, 8'h00, 1);
    endtask

    logic [7:0] pool [10] = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h57, 8'h41, 8'h53, 8'h44, 8'h70, 8'h50};

    initial begin
        int seen_dc;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.step     = 1'b0;

        cyc(1, 0, 8'h00, 0);
        chk("pin_reset_dir", int'(bus.dir), 1);
        chk("pin_reset_level", int'(bus.queue_level), 0);
        chk("pin_reset_link", int'(bus.link_lost), 0);

        seen_dc = 0;
        for (int i = 0; i < 3; i++) begin
            stp();
            seen_dc += int'(bus.dir_changed);
        end
        chk("pin_idle_steps_dir", int'(bus.dir), 1);
        chk("pin_idle_steps_dc", seen_dc, 0);

        send("w"); send("s");
        stp();
        chk("pin_ws_step1_dir", int'(bus.dir), 0);
        chk("pin_ws_step1_dc", int'(bus.dir_changed), 1);
        stp();
        chk("pin_ws_step2_dir", int'(bus.dir), 0);
        chk("pin_ws_step2_dc", int'(bus.dir_changed), 0);
        chk("pin_ws_step2_level", int'(bus.queue_level), 0);

        send("r");
        chk("pin_r_restart", int'(bus.restart), 1);
        send("d");
        chk("pin_dup_level", int'(bus.queue_level), 0);
        chk("pin_dup_ovf", int'(bus.overflow), 0);
        send("w"); send("a"); send("s"); send("d");
        chk("pin_fill_level", int'(bus.queue_level), 4);
        stp(); chk("pin_pop1", int'(bus.dir), 0);
        stp(); chk("pin_pop2", int'(bus.dir), 3);
        stp(); chk("pin_pop3", int'(bus.dir), 2);
        stp(); chk("pin_pop4", int'(bus.dir), 1);

        send("w"); send("a"); send("w"); send("a");
        chk("pin_wawa_ovf", int'(bus.overflow), 0);
        send("w");
        chk("pin_full_ovf", int'(bus.overflow), 1);
        chk("pin_full_level", int'(bus.queue_level), 4);
        idle(1);
        chk("pin_ovf_pulse_end", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) stp();

        send("r");
        send("p"); send("w"); stp(); stp();
        chk("pin_pause_dir", int'(bus.dir), 1);
        chk("pin_pause_level", int'(bus.queue_level), 1);
        chk("pin_pause_flag", int'(bus.paused), 1);
        send("P"); stp();
        chk("pin_unpause_dir", int'(bus.dir), 0);

        send("r"); send("w"); send("a");
        chk("pin_pre_r_level", int'(bus.queue_level), 2);
        cyc(0, 1, "r", 1);
        chk("pin_rstep_restart", int'(bus.restart), 1);
        chk("pin_rstep_dir", int'(bus.dir), 1);
        chk("pin_rstep_level", int'(bus.queue_level), 0);
        chk("pin_rstep_dc", int'(bus.dir_changed), 0);
        idle(1);
        chk("pin_restart_pulse_end", int'(bus.restart), 0);

        idle(TMO - 2);
        chk("pin_wd_before", int'(bus.link_lost), 0);
        idle(1);
        chk("pin_wd_expired", int'(bus.link_lost), 1);
        idle(5);
        chk("pin_wd_held", int'(bus.link_lost), 1);
        send(8'h00);
        chk("pin_wd_cleared", int'(bus.link_lost), 0);
        chk("pin_wd_dir_kept", int'(bus.dir), 1);

        for (int i = 0; i < 3000; i++) begin
            bit         v, s, r;
            int         k;
            logic [7:0] b;
            v = ($urandom_range(0, 9) < 3);
            k = $urandom_range(0, 99);
            if (k < 2)       b = "r";
            else if (k < 80) b = pool[$urandom_range(0, 7)];
            else if (k < 85) b = pool[$urandom_range(8, 9)];
            else             b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 999) == 0);
            cyc(r, v, b, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bt_cmd_scheduler.md
Name: bt_cmd_scheduler

Overview:
- Sits between the 9600-baud Bluetooth byte receiver and the snake game core.
- Decodes received ASCII command bytes (direction, pause, restart) and queues direction requests in a small FIFO.
- Applies at most one queued direction per game step and blocks 180-degree reversals.
- Runs a link watchdog that flags loss of the Bluetooth link.

Parameters:
- FIFO_DEPTH, 4, direction queue depth; power of 2, at least 2.
- TIMEOUT, 500000000, clk cycles without rx_valid before link_lost asserts (5 s at 100 MHz).
- INIT_DIR, 2'b01, direction after reset or restart (00 up, 01 right, 10 down, 11 left).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe, new byte on rx_data
- step  in  1  one-cycle game-step pulse from the game timer
- dir  out  2  current snake direction
- dir_changed  out  1  one-cycle pulse when dir updates
- paused  out  1  pause state; game core halts while 1
- restart  out  1  one-cycle restart pulse to the game core
- overflow  out  1  one-cycle pulse when a direction byte is dropped because the FIFO is full
- queue_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- link_lost  out  1  watchdog expired

Behaviour:
- Single clock; all state is updated on posedge clk. `rst` is synchronous, active-high, and overrides everything.
- Reset values: dir=INIT_DIR, dir_changed=0, paused=0, restart=0, overflow=0, queue_level=0, link_lost=0, FIFO pointers=0, watchdog counter=0.
- Decode applies only when rx_valid=1:
  - 'w'/'W' → 00; 'd'/'D' → 01; 's'/'S' → 10; 'a'/'A' → 11.
  - 'p'/'P' → pause toggle; 'r'/'R' → restart.
  - Any other byte is ignored; it still feeds the watchdog.
- Direction push:
  - Reference value is the last pushed entry if the FIFO is non-empty, otherwise dir.
  - If the decoded direction equals the reference value, drop it silently, with no overflow pulse.
  - Otherwise push if not full.
  - If full and no pop occurs this cycle, drop it and pulse overflow for 1 cycle.
  - If full and a pop occurs in the same cycle, the push succeeds.
  - Pushes are accepted while paused.
- Pop and apply, on step=1 with paused=0 and FIFO non-empty:
  - Pop exactly one entry.
  - If the entry is not equal to dir^2'b10, set dir to the entry and pulse dir_changed the next cycle.
  - If the entry equals dir^2'b10 (reversal), discard it; dir and dir_changed are unchanged.
  - At most one pop per step.
  - On step with an empty FIFO, or while paused, nothing happens.
- Latency: dir and dir_changed are registered outputs, valid the cycle after step.
- Simultaneous push and pop: both occur and queue_level is unchanged. The push reference uses pre-pop FIFO contents.
- Pause: a 'p' byte toggles paused on the next cycle. The FIFO is retained across pause.
- Restart: an 'r' byte, registered, produces in the next cycle:
  - restart=1 for 1 cycle, FIFO flushed (queue_level=0), dir=INIT_DIR, paused=0, dir_changed=0.
  - A step arriving in the same cycle as the 'r' byte is ignored.
  - Restart takes precedence over any pending pop.
- Watchdog:
  - The counter clears on every rx_valid; otherwise it increments and saturates at TIMEOUT.
  - link_lost=1 while the counter equals TIMEOUT.
  - rx_valid clears link_lost on the next cycle.
  - The counter width is sized from TIMEOUT; there is no wrap.
- Pointers wrap modulo FIFO_DEPTH. queue_level ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then step ×3 with no bytes → dir=01, dir_changed never pulses, queue_level=0, paused=0.
- Bytes 'w' then 's', then step, step → first step gives dir=00 and a dir_changed pulse; second step discards 's' (reversal of 00), dir stays 00, queue_level=0.
- 'd' then 'w','a','s','d' with no step (FIFO_DEPTH=4) → 'd' dropped as duplicate, overflow never pulses. Pushes w,a,s,d give queue_level=4; the 4 pops are w→00, a→11, s→10, d→01. Repeat the test with 'w','a','w','a','w' → the fifth byte pulses overflow once and queue_level stays 4.
- 'p', 'w', step ×2, 'P', step → while paused dir=01 and queue_level=1; after unpause the step gives dir=00.
- 'w','a' queued, then 'r' in the same cycle as step → restart pulses 1 cycle, dir=01, queue_level=0, no dir_changed.
- TIMEOUT=100, no rx_valid for 100 cycles → link_lost=1 at cycle 100 and held; then one rx_valid of 0x00 → link_lost=0 the next cycle with no other state change.
